// File: rtl/alarm_pkg.sv
// Shared types, limits and BCD helpers for the alarm controller.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    localparam int MIN_MAX    = 59;
    localparam int HOUR_MAX   = 23;
    localparam int RING_CNT_W = 8;

    function automatic logic [6:0] bcd_to_bin(input logic [3:0] d1, input logic [3:0] d0);
        return ({3'b000, d1} * 7'd10) + {3'b000, d0};
    endfunction

    function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    // Minute digits step 00..59 and wrap without carry.
    function automatic logic [7:0] bcd_inc_min(input logic [3:0] d1, input logic [3:0] d0);
        logic [7:0] r;
        if (bcd_to_bin(d1, d0) >= 7'(MIN_MAX)) begin
            r = 8'h00;
        end else if (d0 == 4'd9) begin
            r = {d1 + 4'd1, 4'd0};
        end else begin
            r = {d1, d0 + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc_hour(input logic [3:0] d1, input logic [3:0] d0);
        logic [7:0] r;
        if (bcd_to_bin(d1, d0) >= 7'(HOUR_MAX)) begin
            r = 8'h00;
        end else if (d0 == 4'd9) begin
            r = {d1 + 4'd1, 4'd0};
        end else begin
            r = {d1, d0 + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_ctrl_bcd_time_add.sv
// Combinational BCD hh:mm + ADD_MIN minutes, carrying into hours and wrapping at 24h.
module bcd_time_add
    import alarm_pkg::*;
#(
    parameter int ADD_MIN = 5
) (
    input  logic [3:0] h1,
    input  logic [3:0] h0,
    input  logic [3:0] m1,
    input  logic [3:0] m0,
    output logic [3:0] sum_h1,
    output logic [3:0] sum_h0,
    output logic [3:0] sum_m1,
    output logic [3:0] sum_m0
);

    logic [6:0] m_sum_s;
    logic [6:0] m_wrap_s;
    logic [6:0] h_sum_s;
    logic [6:0] h_wrap_s;
    logic       carry_s;

    // Binary add of minutes, then carry and hour wrap, then back to BCD.
    always_comb begin
        m_sum_s = bcd_to_bin(m1, m0) + 7'(ADD_MIN);
        if (m_sum_s > 7'(MIN_MAX)) begin
            m_wrap_s = m_sum_s - 7'(MIN_MAX + 1);
            carry_s  = 1'b1;
        end else begin
            m_wrap_s = m_sum_s;
            carry_s  = 1'b0;
        end
        h_sum_s = bcd_to_bin(h1, h0) + {6'b000000, carry_s};
        if (h_sum_s > 7'(HOUR_MAX)) begin
            h_wrap_s = h_sum_s - 7'(HOUR_MAX + 1);
        end else begin
            h_wrap_s = h_sum_s;
        end
        {sum_h1, sum_h0} = bin_to_bcd(h_wrap_s);
        {sum_m1, sum_m0} = bin_to_bcd(m_wrap_s);
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: alarm edit counters, match detection, ring/snooze FSM, beeper enable.
// Optional hourly chime is built when ALARM_HOURLY_CHIME_EN is defined.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [3:0] cur_h1,
    input  logic [3:0] cur_h0,
    input  logic [3:0] cur_m1,
    input  logic [3:0] cur_m0,
    input  logic [3:0] cur_s1,
    input  logic [3:0] cur_s0,
    input  logic       set_en,
    input  logic       inc_min,
    input  logic       inc_hour,
    input  logic       alarm_on,
    input  logic       stop,
    input  logic       snooze,
    output logic [3:0] alm_h1,
    output logic [3:0] alm_h0,
    output logic [3:0] alm_m1,
    output logic [3:0] alm_m0,
    output logic       bee_en,
    output logic       ringing,
    output logic       snoozed,
    output logic       chime
);

    state_t                  state_r, state_next_s;
    logic [RING_CNT_W-1:0]   ring_cnt_r, ring_cnt_next_s;
    logic [7:0]              alm_h_r, alm_m_r, alm_h_next_s, alm_m_next_s;
    logic [7:0]              snz_h_r, snz_m_r;
    logic [15:0]             cur_hm_s, tgt_hm_s;
    logic                    match_now_s, match_prev_r, trigger_s, snz_load_s;
    logic [3:0]              snz_h1_s, snz_h0_s, snz_m1_s, snz_m0_s;
    logic                    chime_r, chime_next_s;
    logic                    ringing_r, snoozed_r, bee_en_r;

    bcd_time_add #(.ADD_MIN(SNOOZE_MIN)) u_snz_add (
        .h1     (cur_h1),
        .h0     (cur_h0),
        .m1     (cur_m1),
        .m0     (cur_m0),
        .sum_h1 (snz_h1_s),
        .sum_h0 (snz_h0_s),
        .sum_m1 (snz_m1_s),
        .sum_m0 (snz_m0_s)
    );

    // Alarm edit: pulses honoured only in edit mode, both may apply together.
    always_comb begin
        alm_h_next_s = alm_h_r;
        alm_m_next_s = alm_m_r;
        if (set_en) begin
            if (inc_min) begin
                alm_m_next_s = bcd_inc_min(alm_m_r[7:4], alm_m_r[3:0]);
            end else begin
                alm_m_next_s = alm_m_r;
            end
            if (inc_hour) begin
                alm_h_next_s = bcd_inc_hour(alm_h_r[7:4], alm_h_r[3:0]);
            end else begin
                alm_h_next_s = alm_h_r;
            end
        end else begin
            alm_h_next_s = alm_h_r;
            alm_m_next_s = alm_m_r;
        end
    end

    // Match against the active target; edge-detect so each matching minute fires once.
    always_comb begin
        cur_hm_s = {cur_h1, cur_h0, cur_m1, cur_m0};
        if (state_r == SNOOZE) begin
            tgt_hm_s = {snz_h_r, snz_m_r};
        end else begin
            tgt_hm_s = {alm_h_r, alm_m_r};
        end
        match_now_s = (cur_hm_s == tgt_hm_s) && (cur_s1 == 4'd0) && (cur_s0 == 4'd0);
        trigger_s   = match_now_s && !match_prev_r;
    end

    // FSM next state; exit priority in RING is alarm_on=0 > stop > snooze > timeout.
    always_comb begin
        state_next_s    = state_r;
        ring_cnt_next_s = ring_cnt_r;
        snz_load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (trigger_s && alarm_on && !set_en) begin
                    state_next_s    = RING;
                    ring_cnt_next_s = '0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RING: begin
                if (!alarm_on || stop) begin
                    state_next_s = IDLE;
                end else if (snooze) begin
                    state_next_s = SNOOZE;
                    snz_load_s   = 1'b1;
                end else if (tick_1hz) begin
                    if (ring_cnt_r == RING_CNT_W'(RING_SEC - 1)) begin
                        state_next_s = IDLE;
                    end else begin
                        ring_cnt_next_s = ring_cnt_r + RING_CNT_W'(1);
                    end
                end else begin
                    state_next_s = RING;
                end
            end
            SNOOZE: begin
                if (!alarm_on || stop) begin
                    state_next_s = IDLE;
                end else if (trigger_s) begin
                    state_next_s    = RING;
                    ring_cnt_next_s = '0;
                end else begin
                    state_next_s = SNOOZE;
                end
            end
            default: begin
                state_next_s    = IDLE;
                ring_cnt_next_s = '0;
            end
        endcase
    end

`ifdef ALARM_HOURLY_CHIME_EN
    logic top_hour_s, top_hour_prev_r;

    // Chime on the rising edge of mm:ss==00:00 while armed and idle; drop on tick or state exit.
    always_comb begin
        top_hour_s = ({cur_m1, cur_m0, cur_s1, cur_s0} == 16'h0000);
        if (state_next_s != IDLE) begin
            chime_next_s = 1'b0;
        end else if (state_r == IDLE && alarm_on && top_hour_s && !top_hour_prev_r) begin
            chime_next_s = 1'b1;
        end else if (tick_1hz) begin
            chime_next_s = 1'b0;
        end else begin
            chime_next_s = chime_r;
        end
    end

    // Top-of-hour history for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_hour_prev_r <= 1'b0;
        end else begin
            top_hour_prev_r <= top_hour_s;
        end
    end
`else
    // Chime feature not built.
    always_comb begin
        chime_next_s = 1'b0;
    end
`endif

    // State, counters, targets and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            ring_cnt_r   <= '0;
            alm_h_r      <= 8'h00;
            alm_m_r      <= 8'h00;
            snz_h_r      <= 8'h00;
            snz_m_r      <= 8'h00;
            match_prev_r <= 1'b0;
            chime_r      <= 1'b0;
            ringing_r    <= 1'b0;
            snoozed_r    <= 1'b0;
            bee_en_r     <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            ring_cnt_r   <= ring_cnt_next_s;
            alm_h_r      <= alm_h_next_s;
            alm_m_r      <= alm_m_next_s;
            match_prev_r <= match_now_s;
            chime_r      <= chime_next_s;
            ringing_r    <= (state_next_s == RING);
            snoozed_r    <= (state_next_s == SNOOZE);
            bee_en_r     <= (state_next_s == RING) || chime_next_s;
            if (snz_load_s) begin
                snz_h_r <= {snz_h1_s, snz_h0_s};
                snz_m_r <= {snz_m1_s, snz_m0_s};
            end else begin
                snz_h_r <= snz_h_r;
                snz_m_r <= snz_m_r;
            end
        end
    end

    assign {alm_h1, alm_h0} = alm_h_r;
    assign {alm_m1, alm_m0} = alm_m_r;
    assign bee_en  = bee_en_r;
    assign ringing = ringing_r;
    assign snoozed = snoozed_r;
    assign chime   = chime_r;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl (default parameters RING_SEC=60, SNOOZE_MIN=5).
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz, set_en, inc_min, inc_hour, alarm_on, stop, snooze;
    logic [3:0] cur_h1, cur_h0, cur_m1, cur_m0, cur_s1, cur_s0;
    logic [3:0] alm_h1, alm_h0, alm_m1, alm_m0;
    logic       bee_en, ringing, snoozed, chime;

    int errors = 0;
    int checks = 0;

`ifdef ALARM_HOURLY_CHIME_EN
    localparam logic CHIME_EXP = 1'b1;
`else
    localparam logic CHIME_EXP = 1'b0;
`endif

    alarm_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .cur_h1   (cur_h1),
        .cur_h0   (cur_h0),
        .cur_m1   (cur_m1),
        .cur_m0   (cur_m0),
        .cur_s1   (cur_s1),
        .cur_s0   (cur_s0),
        .set_en   (set_en),
        .inc_min  (inc_min),
        .inc_hour (inc_hour),
        .alarm_on (alarm_on),
        .stop     (stop),
        .snooze   (snooze),
        .alm_h1   (alm_h1),
        .alm_h0   (alm_h0),
        .alm_m1   (alm_m1),
        .alm_m0   (alm_m0),
        .bee_en   (bee_en),
        .ringing  (ringing),
        .snoozed  (snoozed),
        .chime    (chime)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        {cur_h1, cur_h0} = h;
        {cur_m1, cur_m0} = m;
        {cur_s1, cur_s0} = s;
    endtask

    task automatic pulse_min(input int n);
        for (int i = 0; i < n; i++) begin
            inc_min = 1'b1; cyc(); inc_min = 1'b0; cyc();
        end
    endtask

    task automatic pulse_hour(input int n);
        for (int i = 0; i < n; i++) begin
            inc_hour = 1'b1; cyc(); inc_hour = 1'b0; cyc();
        end
    endtask

    task automatic check_outs(input string tag, input logic r, input logic s, input logic b);
        check({tag, "_ringing"}, {31'd0, ringing}, {31'd0, r});
        check({tag, "_snoozed"}, {31'd0, snoozed}, {31'd0, s});
        check({tag, "_bee_en"},  {31'd0, bee_en},  {31'd0, b});
    endtask

    // Cur 23:57:59 -> 23:58:00 against alarm 23:58 starts ringing.
    task automatic ring_at_2358(input string tag);
        set_cur(8'h23, 8'h57, 8'h59); cyc();
        set_cur(8'h23, 8'h58, 8'h00); cyc();
        check_outs(tag, 1'b1, 1'b0, 1'b1);
    endtask

    function automatic logic [31:0] alm();
        return {16'd0, alm_h1, alm_h0, alm_m1, alm_m0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {tick_1hz, set_en, inc_min, inc_hour, alarm_on, stop, snooze} = 7'd0;
        set_cur(8'h12, 8'h00, 8'h30);
        cyc(); cyc();
        check("rst_alm", alm(), 32'h0000);
        check_outs("rst", 1'b0, 1'b0, 1'b0);
        check("rst_chime", {31'd0, chime}, 32'd0);
        rst = 1'b0;
        cyc();

        // Edit to 07:30, then ignored pulses outside edit mode.
        set_en = 1'b1;
        pulse_hour(7);
        pulse_min(30);
        check("set_0730", alm(), 32'h0730);
        set_en = 1'b0;
        pulse_min(1);
        pulse_hour(1);
        check("noedit", alm(), 32'h0730);

        // Wrap without carry, then simultaneous pulses.
        set_en = 1'b1;
        pulse_hour(16);
        pulse_min(29);
        check("set_2359", alm(), 32'h2359);
        pulse_min(1);
        check("min_wrap", alm(), 32'h2300);
        pulse_hour(1);
        check("hour_wrap", alm(), 32'h0000);
        inc_min = 1'b1; inc_hour = 1'b1; cyc(); inc_min = 1'b0; inc_hour = 1'b0;
        check("both_inc", alm(), 32'h0101);
        pulse_hour(6);
        pulse_min(29);
        check("reset_0730", alm(), 32'h0730);
        set_en = 1'b0;

        // Ring then time out after 60 ticks.
        alarm_on = 1'b1;
        set_cur(8'h07, 8'h29, 8'h59); cyc();
        check_outs("pre_match", 1'b0, 1'b0, 1'b0);
        set_cur(8'h07, 8'h30, 8'h00); cyc();
        check_outs("ring_start", 1'b1, 1'b0, 1'b1);
        cyc(); cyc();
        check_outs("ring_hold", 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 60; i++) begin
            tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
            if (i < 60) begin
                set_cur(8'h07, 8'h30, {4'(i / 10), 4'(i % 10)});
            end else begin
                set_cur(8'h07, 8'h31, 8'h00);
            end
            cyc();
            if (i == 59) begin
                check_outs("ring_59", 1'b1, 1'b0, 1'b1);
            end
        end
        check_outs("timeout", 1'b0, 1'b0, 1'b0);
        cyc(); cyc();
        check_outs("no_retrig", 1'b0, 1'b0, 1'b0);

        // Snooze across midnight: 23:58 + 5 -> 00:03.
        set_en = 1'b1;
        pulse_hour(16);
        pulse_min(28);
        check("set_2358", alm(), 32'h2358);
        set_en = 1'b0;
        ring_at_2358("snz_ring");
        snooze = 1'b1; cyc(); snooze = 1'b0;
        check_outs("snoozed", 1'b0, 1'b1, 1'b0);
        set_cur(8'h23, 8'h59, 8'h00); cyc();
        snooze = 1'b1; cyc(); snooze = 1'b0;
        check_outs("snz_wait", 1'b0, 1'b1, 1'b0);
        set_cur(8'h00, 8'h03, 8'h00); cyc();
        check_outs("snz_reRing", 1'b1, 1'b0, 1'b1);
        stop = 1'b1; cyc(); stop = 1'b0;
        check_outs("stop", 1'b0, 1'b0, 1'b0);

        // stop beats snooze; alarm_on=0 aborts SNOOZE.
        ring_at_2358("prio_ring");
        stop = 1'b1; snooze = 1'b1; cyc(); stop = 1'b0; snooze = 1'b0;
        check_outs("stop_snz", 1'b0, 1'b0, 1'b0);
        ring_at_2358("off_ring");
        snooze = 1'b1; cyc(); snooze = 1'b0;
        check_outs("off_snz", 1'b0, 1'b1, 1'b0);
        alarm_on = 1'b0; cyc();
        check_outs("off_idle", 1'b0, 1'b0, 1'b0);
        alarm_on = 1'b1;

        // Asynchronous reset during RING.
        ring_at_2358("rst_ring");
        rst = 1'b1; #1;
        check("arst_bee", {31'd0, bee_en}, 32'd0);
        check("arst_alm", alm(), 32'h0000);
        cyc(); rst = 1'b0; cyc();
        check_outs("post_rst", 1'b0, 1'b0, 1'b0);

        // Hourly chime (only with the option built).
        set_cur(8'h09, 8'h59, 8'h59); cyc();
        set_cur(8'h10, 8'h00, 8'h00); cyc();
        check("chime_set", {31'd0, chime}, {31'd0, CHIME_EXP});
        check("chime_bee", {31'd0, bee_en}, {31'd0, CHIME_EXP});
        cyc();
        check("chime_hold", {31'd0, chime}, {31'd0, CHIME_EXP});
        tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
        check("chime_clr", {31'd0, chime}, 32'd0);
        check("chime_clr_bee", {31'd0, bee_en}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
